red_adc_sampler: RTL and testbench



---
 rtl/red_adc_pkg.sv | 12 +
 rtl/red_adc_sclk_divider.sv | 42 ++++
 rtl/red_adc_sampler.sv | 135 +++++++++++++
 tb/tb_red_adc_sampler.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/red_adc_pkg.sv
// red_adc_pkg: FSM states and frame constants shared by the RED ADC sampler.
// Optional feature macro: RED_AVG4_EN (adds AVG_DEPTH for 4-sample averaging).
package red_adc_pkg;
   typedef enum logic [2:0] {IDLE, SETTLE, CS_SETUP, SHIFT, DONE} state_t;
   localparam int ADC_DATA_BITS = 8;
   localparam int ADC_NULL_BITS = 1;
   localparam int SCLK_PERIODS  = 9;
   localparam int FRAME_BITS    = ADC_DATA_BITS + ADC_NULL_BITS;
`ifdef RED_AVG4_EN
   localparam int AVG_DEPTH = 4;
`endif
endpackage

// File: rtl/red_adc_sclk_divider.sv
// adc_sclk_divider: SCLK generator for one ADC frame (SCLK_PERIODS full periods).
// Ports:
//   clk, rst  clock and synchronous active-high reset
//   i_run     high while shifting; low holds counters at the start of a frame
//   o_sclk    SCLK level (starts high: the low setup half is spent in CS_SETUP)
//   o_rise    high in the first cycle of each high half
//   o_fall    high in the first cycle of each low half
//   o_done    high in the last cycle of the final low half
module adc_sclk_divider
   import red_adc_pkg::*;
#(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic i_run,
   output logic o_sclk,
   output logic o_rise,
   output logic o_fall,
   output logic o_done
);
   localparam int DW = $clog2(CLK_DIV + 1);
   localparam int HW = $clog2(2 * SCLK_PERIODS);
   logic [DW-1:0] r_cnt;
   logic [HW-1:0] r_half;
   logic w_last, w_final;
   assign w_last  = r_cnt == DW'(CLK_DIV - 1);
   assign w_final = r_half == HW'(2 * SCLK_PERIODS - 1);
   always_ff @(posedge clk)
      if (rst || !i_run) begin
         r_cnt  <= '0;
         r_half <= '0;
      end else if (w_last) begin
         r_cnt  <= '0;
         r_half <= w_final ? '0 : r_half + 1'b1;
      end else
         r_cnt <= r_cnt + 1'b1;
   assign o_sclk = i_run & ~r_half[0];
   assign o_rise = i_run & ~r_half[0] & (r_cnt == '0);
   assign o_fall = i_run & r_half[0] & (r_cnt == '0);
   assign o_done = i_run & w_last & w_final;
endmodule

// File: rtl/red_adc_sampler.sv
// red_adc_sampler: times the RED LED pulse and reads an ADC0831-style serial ADC.
// Ports:
//   CLK_Filter, rst  filter clock, synchronous active-high reset
//   enable           allows new conversion triggers
//   ADC_DOUT         serial data from the ADC (null bit, then D7..D0)
//   ADC_CS_n         ADC chip select, active-low
//   ADC_SCLK         ADC serial clock
//   LED_RED          RED LED drive
//   RED_ADC_Value    latest good sample
//   RED_Valid        one-cycle strobe, RED_ADC_Value is new
//   Null_Err         one-cycle pulse, frame had a non-zero null bit
//   Overrun          one-cycle pulse, trigger arrived while busy
// Optional feature macro: RED_AVG4_EN (output the mean of every 4 good samples).
module red_adc_sampler
   import red_adc_pkg::*;
#(
   parameter int CLK_DIV       = 4,
   parameter int SETTLE_CYCLES = 16,
   parameter int SAMPLE_PERIOD = 512
) (
   input  logic                     CLK_Filter,
   input  logic                     rst,
   input  logic                     enable,
   input  logic                     ADC_DOUT,
   output logic                     ADC_CS_n,
   output logic                     ADC_SCLK,
   output logic                     LED_RED,
   output logic [ADC_DATA_BITS-1:0] RED_ADC_Value,
   output logic                     RED_Valid,
   output logic                     Null_Err,
   output logic                     Overrun
);
   localparam int TW = $clog2(SAMPLE_PERIOD);
   localparam int CW = $clog2(SETTLE_CYCLES + CLK_DIV + 1);
   if (CLK_DIV < 1 || SETTLE_CYCLES < 1 || SAMPLE_PERIOD <= SETTLE_CYCLES + 20 * CLK_DIV + 4) begin : g_bad_params
      $error("red_adc_sampler: SAMPLE_PERIOD too short for one conversion");
   end
   state_t                r_state, w_next;
   logic [TW-1:0]         r_timer;
   logic [CW-1:0]         r_cnt;
   logic [FRAME_BITS-1:0] r_shift;
   logic                  r_bit;
   logic                  w_wrap, w_trig, w_run, w_rise, w_fall, w_done, w_good;
   assign w_wrap = r_timer == TW'(SAMPLE_PERIOD - 1);
   assign w_trig = w_wrap & enable;
   assign w_good = w_done & ~r_shift[FRAME_BITS-1];
   always_ff @(posedge CLK_Filter)
      if (rst) r_timer <= '0;
      else     r_timer <= w_wrap ? '0 : r_timer + 1'b1;
   always_ff @(posedge CLK_Filter)
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   always_comb begin
      w_next   = r_state;
      ADC_CS_n = 1'b1;
      LED_RED  = 1'b0;
      w_run    = 1'b0;
      case (r_state)
         IDLE:     w_next = w_trig ? SETTLE : IDLE;
         SETTLE: begin
            LED_RED = 1'b1;
            w_next  = (r_cnt == CW'(SETTLE_CYCLES - 1)) ? CS_SETUP : SETTLE;
         end
         CS_SETUP: begin
            LED_RED  = 1'b1;
            ADC_CS_n = 1'b0;
            w_next   = (r_cnt == CW'(CLK_DIV - 1)) ? SHIFT : CS_SETUP;
         end
         SHIFT: begin
            LED_RED  = 1'b1;
            ADC_CS_n = 1'b0;
            w_run    = 1'b1;
            w_next   = w_done ? DONE : SHIFT;
         end
         default:  w_next = IDLE;
      endcase
   end
   // Dwell counter restarts on every state change
   always_ff @(posedge CLK_Filter)
      if (rst || r_state != w_next) r_cnt <= '0;
      else                          r_cnt <= r_cnt + 1'b1;
   adc_sclk_divider #(.CLK_DIV(CLK_DIV)) u_div (
      .clk   (CLK_Filter),
      .rst   (rst),
      .i_run (w_run),
      .o_sclk(ADC_SCLK),
      .o_rise(w_rise),
      .o_fall(w_fall),
      .o_done(w_done)
   );
   // DOUT is captured as SCLK rises and committed to the frame on the following fall,
   // so the frame is complete (null bit at the top) well before the done strobe.
   always_ff @(posedge CLK_Filter)
      if (rst) begin
         r_bit    <= 1'b0;
         r_shift  <= '0;
         Null_Err <= 1'b0;
         Overrun  <= 1'b0;
      end else begin
         if (w_rise) r_bit <= ADC_DOUT;
         if (w_fall) r_shift <= {r_shift[FRAME_BITS-2:0], r_bit};
         Null_Err <= w_done & r_shift[FRAME_BITS-1];
         Overrun  <= w_trig & (r_state != IDLE);
      end
`ifdef RED_AVG4_EN
   logic [9:0] r_acc, w_sum;
   logic [1:0] r_avg_cnt;
   logic       w_last_avg;
   assign w_sum      = r_acc + 10'(r_shift[ADC_DATA_BITS-1:0]);
   assign w_last_avg = r_avg_cnt == 2'(AVG_DEPTH - 1);
   always_ff @(posedge CLK_Filter)
      if (rst) begin
         r_acc         <= '0;
         r_avg_cnt     <= '0;
         RED_ADC_Value <= '0;
         RED_Valid     <= 1'b0;
      end else begin
         RED_Valid <= w_good & w_last_avg;
         if (w_good) begin
            r_acc     <= w_last_avg ? '0 : w_sum;
            r_avg_cnt <= w_last_avg ? '0 : r_avg_cnt + 1'b1;
         end
         if (w_good && w_last_avg) RED_ADC_Value <= w_sum[9:2];
      end
`else
   always_ff @(posedge CLK_Filter)
      if (rst) begin
         RED_ADC_Value <= '0;
         RED_Valid     <= 1'b0;
      end else begin
         RED_Valid <= w_good;
         if (w_good) RED_ADC_Value <= r_shift[ADC_DATA_BITS-1:0];
      end
`endif
endmodule

// File: tb/tb_red_adc_sampler.sv
// tb_red_adc_sampler: self-checking bench with an ADC0831 model and a per-period reference model.
module tb_red_adc_sampler;
   localparam int CLK_DIV = 2;
   localparam int SETTLE  = 4;
   localparam int PERIOD  = 64;
   localparam int LAT     = SETTLE + 19 * CLK_DIV + 1;
   localparam int CS_LOW  = 19 * CLK_DIV;
   localparam int LED_ON  = SETTLE + 19 * CLK_DIV;
   logic       clk = 1'b0, rst = 1'b1, enable = 1'b1, adc_dout = 1'b0;
   logic       cs_n, sclk, led, valid, null_err, overrun;
   logic [7:0] value;
   int         n_cmp = 0, n_err = 0;
   int         ph = 0, cyc = 0, exp_val = 0;
   logic [8:0] adc_word = '0;
   int         adc_pos = 0;
   logic       adc_prev = 1'b0;
`ifdef RED_AVG4_EN
   int         good_q[$];
`endif
   red_adc_sampler #(.CLK_DIV(CLK_DIV), .SETTLE_CYCLES(SETTLE), .SAMPLE_PERIOD(PERIOD)) dut (
      .CLK_Filter   (clk),
      .rst          (rst),
      .enable       (enable),
      .ADC_DOUT     (adc_dout),
      .ADC_CS_n     (cs_n),
      .ADC_SCLK     (sclk),
      .LED_RED      (led),
      .RED_ADC_Value(value),
      .RED_Valid    (valid),
      .Null_Err     (null_err),
      .Overrun      (overrun)
   );
   always #5 clk = ~clk;
   // ADC: presents the null bit once selected, advances one bit per SCLK fall
   always @(negedge clk) begin
      if (cs_n) adc_pos = 0;
      else if (adc_prev && !sclk) adc_pos = adc_pos + 1;
      adc_prev = sclk;
      adc_dout = (adc_pos < 9) ? adc_word[8 - adc_pos] : 1'b0;
   end
   task automatic check(input string tag, input int obs, input int exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask
   task automatic step();
      @(negedge clk);
      ph  = (ph + 1) % PERIOD;
      cyc = cyc + 1;
   endtask
   // Reference: what one delivered frame should produce
   task automatic model_sample(input logic [8:0] w, output bit v, output bit ne);
      ne = w[8];
      v  = 1'b0;
      if (!w[8]) begin
`ifdef RED_AVG4_EN
         good_q.push_back(int'(w[7:0]));
         if (good_q.size() == 4) begin
            exp_val = good_q.sum() / 4;
            good_q.delete();
            v = 1'b1;
         end
`else
         exp_val = int'(w[7:0]);
         v = 1'b1;
`endif
      end
   endtask
   task automatic model_reset();
      exp_val = 0;
`ifdef RED_AVG4_EN
      good_q.delete();
`endif
   endtask
   // Runs one full sample period starting at the negedge of a trigger cycle
   task automatic window(input logic [8:0] w, input int drop_at, input string tag, output int vcyc);
      bit   trig, v, ne;
      int   n_led, n_cs, n_rise, n_v, v_at, v_val, n_ne, ne_at, n_ov;
      logic psclk;
      n_led = 0; n_cs = 0; n_rise = 0; n_v = 0; v_at = -1; v_val = -1;
      n_ne = 0; ne_at = -1; n_ov = 0; psclk = 1'b0; vcyc = -1;
      trig = enable;
      adc_word = w;
      v = 1'b0;
      ne = 1'b0;
      if (trig) model_sample(w, v, ne);
      for (int i = 1; i <= PERIOD; i++) begin
         step();
         if (i == drop_at) enable = 1'b0;
         n_led  += int'(led);
         n_cs   += int'(!cs_n);
         n_rise += int'(sclk && !psclk);
         psclk = sclk;
         if (valid) begin
            n_v++;
            v_at  = i;
            v_val = int'(value);
            vcyc  = cyc;
         end
         if (null_err) begin
            n_ne++;
            ne_at = i;
         end
         n_ov += int'(overrun);
      end
      check({tag, " led_cycles"}, n_led, trig ? LED_ON : 0);
      check({tag, " cs_low_cycles"}, n_cs, trig ? CS_LOW : 0);
      check({tag, " sclk_rises"}, n_rise, trig ? 9 : 0);
      check({tag, " valid_count"}, n_v, int'(v));
      if (v) begin
         check({tag, " valid_latency"}, v_at, LAT);
         check({tag, " valid_value"}, v_val, exp_val);
      end
      check({tag, " null_count"}, n_ne, int'(ne));
      if (ne) check({tag, " null_latency"}, ne_at, LAT);
      check({tag, " overrun_count"}, n_ov, 0);
      check({tag, " held_value"}, int'(value), exp_val);
   endtask
   initial begin
      logic [8:0] w;
      int         t0, t1, n_r, n_v;
      bit         hit;
      logic       psclk;
      rst = 1'b1;
      enable = 1'b1;
      repeat (3) @(negedge clk);
      check("reset cs_n", int'(cs_n), 1);
      check("reset sclk", int'(sclk), 0);
      check("reset led", int'(led), 0);
      check("reset value", int'(value), 0);
      check("reset valid", int'(valid), 0);
      check("reset null_err", int'(null_err), 0);
      check("reset overrun", int'(overrun), 0);
      rst = 1'b0;
      ph = 0;
      while (ph != PERIOD - 1) step();
      window(9'h0A5, 0, "a5", t0);
      window(9'h000, 0, "x00", t0);
      window(9'h0FF, 0, "xff", t1);
      if (t0 >= 0 && t1 >= 0) check("valid spacing", t1 - t0, PERIOD);
      window(9'h13C, 0, "null3c", t0);
      for (int k = 0; k < 4; k++) begin
         w = {($urandom_range(0, 3) == 0), 8'($urandom)};
         window(w, 0, "random", t0);
      end
      w = {1'b0, 8'($urandom)};
      window(w, SETTLE + CLK_DIV + 14, "enable_drop", t0);
      window(9'h0C3, 0, "disabled", t0);
      enable = 1'b1;
      // Abort a conversion with reset at the 5th SCLK rise
      adc_word = 9'h05A;
      hit = 1'b0;
      n_r = 0;
      psclk = 1'b0;
      for (int i = 1; i <= PERIOD && !hit; i++) begin
         step();
         if (sclk && !psclk) n_r++;
         psclk = sclk;
         hit = (n_r == 5);
      end
      check("abort reached rise5", int'(hit), 1);
      rst = 1'b1;
      step();
      check("abort cs_n", int'(cs_n), 1);
      check("abort sclk", int'(sclk), 0);
      check("abort led", int'(led), 0);
      check("abort valid", int'(valid), 0);
      rst = 1'b0;
      ph = 0;
      model_reset();
      n_v = 0;
      while (ph != PERIOD - 1) begin
         step();
         n_v += int'(valid) + int'(led) + int'(!cs_n);
      end
      check("abort no activity", n_v, 0);
      check("abort value", int'(value), exp_val);
      window(9'd10, 0, "avg10", t0);
      window(9'd20, 0, "avg20", t0);
      window(9'd30, 0, "avg30", t0);
      window(9'd41, 0, "avg41", t0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
